// File: rtl/div_unit.sv
// Multicycle radix-2 restoring divider (DIV/DIVU) behind a start/busy handshake.
// Optional feature macro: DIV_EARLY_EXIT_EN skips the iteration when the quotient is trivially zero.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] dvd_raw;
    logic             sq;
    logic             sr;
    logic             dz;

    // Operand magnitudes; the most negative value maps onto itself as an unsigned magnitude.
    logic [WIDTH-1:0] dvd_mag_c;
    logic [WIDTH-1:0] dsr_mag_c;
    assign dvd_mag_c = (is_signed && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
    assign dsr_mag_c = (is_signed && divisor[WIDTH-1])  ? (~divisor  + WIDTH'(1)) : divisor;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH-1:0] diff_c;
    logic             fits_c;
    assign shifted_c = {rem, quo[WIDTH-1]};
    assign fits_c    = (shifted_c >= {1'b0, dsr});
    assign diff_c    = shifted_c[WIDTH-1:0] - dsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dsr     <= '0;
            dvd_raw <= '0;
            sq      <= 1'b0;
            sr      <= 1'b0;
            dz      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            lo      <= '0;
            hi      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dsr     <= dsr_mag_c;
                        dvd_raw <= dividend;
                        sq      <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sr      <= is_signed & dividend[WIDTH-1];
                        dz      <= (divisor == '0);
                        count   <= CW'(WIDTH - 1);
                        busy    <= 1'b1;
`ifdef DIV_EARLY_EXIT_EN
                        if ((divisor == '0) || (dvd_mag_c < dsr_mag_c)) begin
                            rem   <= dvd_mag_c;
                            quo   <= '0;
                            state <= FIX;
                        end else begin
                            rem   <= '0;
                            quo   <= dvd_mag_c;
                            state <= CALC;
                        end
`else
                        rem   <= '0;
                        quo   <= dvd_mag_c;
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (fits_c) begin
                        rem <= diff_c;
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted_c[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                FIX: begin
                    if (dz) begin
                        lo <= '1;
                        hi <= dvd_raw;
                    end else begin
                        lo <= sq ? (~quo + WIDTH'(1)) : quo;
                        hi <= sr ? (~rem + WIDTH'(1)) : rem;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected quotient/remainder/busy length.
// Define DIV_EARLY_EXIT_EN for both RTL and bench to exercise the early-exit build.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .lo        (lo),
        .hi        (hi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cyc(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (sgn && a[31]) ? 32'(0 - a) : a;
        mb = (sgn && b[31]) ? 32'(0 - b) : b;
`ifdef DIV_EARLY_EXIT_EN
        if (b == 32'd0 || ma < mb) return 1;
`endif
        if (ma == mb) return 33;
        return 33;
    endfunction

    // Called at a falling edge; start is seen by the following rising edge.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi);
        exp_t e;
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        e.lo  = elo;
        e.hi  = ehi;
        e.cyc = exp_cyc(sgn, a, b);
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        chk("busy_rise", 32'(busy), 32'd1);
        chk("done_low_at_accept", 32'(done), 32'd0);
        chk("lo_held", lo, last_lo);
        chk("hi_held", hi, last_hi);
    endtask

    task automatic wait_result(input string tag, input int inject_at);
        exp_t e;
        int   cyc;
        cyc = 1;
        while (busy === 1'b1 && cyc < 200) begin
            if (cyc == inject_at) begin
                start     = 1'b1;
                is_signed = 1'b1;
                dividend  = 32'd5;
                divisor   = 32'd3;
            end
            @(negedge clk);
            start = 1'b0;
            if (busy === 1'b1) cyc++;
        end
        chk({tag, "_busy_fell"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_busy_cycles"}, 32'(cyc), 32'(e.cyc));
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_lo"}, lo, e.lo);
            chk({tag, "_hi"}, hi, e.hi);
            last_lo = e.lo;
            last_hi = e.hi;
        end
    endtask

    task automatic idle1();
        @(negedge clk);
        chk("done_one_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        exp_t        drop;

        #1 rst = 1'b1;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_hi", hi, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        wait_result("divu_100_7", 0);
        idle1();
        issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        wait_result("div_m7_2", 0);
        idle1();
        issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
        wait_result("div_7_m2", 0);
        // Back-to-back: start in the done cycle
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
        wait_result("div_overflow", 0);
        idle1();
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
        wait_result("divu_max_1", 0);
        idle1();
        issue(1'b0, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234);
        wait_result("divu_by_zero", 0);
        idle1();
        issue(1'b1, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FF00);
        wait_result("div_by_zero_neg", 0);
        idle1();
        issue(1'b0, 32'd3, 32'd10, 32'd0, 32'd3);
        wait_result("divu_3_10", 0);
        idle1();

        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        wait_result("start_mid_calc", 5);
        issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
        wait_result("after_done_accept", 0);
        idle1();

        repeat (4) begin
            a = $urandom;
            b = 32'($urandom_range(1, 65535));
            issue(1'b0, a, b, a / b, a % b);
            wait_result("divu_random", 0);
            idle1();
        end

        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midop_reset_busy", 32'(busy), 32'd0);
        chk("midop_reset_done", 32'(done), 32'd0);
        chk("midop_reset_lo", lo, 32'd0);
        chk("midop_reset_hi", hi, 32'd0);
        drop = sb.pop_front();
        last_lo = '0;
        last_hi = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        wait_result("after_reset", 0);
        idle1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle radix-2 restoring divider; it is the responder side of the controller's DIV/DIVU start/busy handshake.
- The controller pulses start in T3 and then holds in T4 while busy=1. In the first T4 cycle with busy=0 it writes hi/lo into the HI/LO registers.
- A single instance serves both DIV and DIVU. The is_signed input selects the mode; the controller's DIV_busy and DIVU_busy are both driven from busy.

Parameters:
WIDTH, 32, operand/result width in bits; must be >=2.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request strobe; sampled only in IDLE
is_signed  input  1  1=DIV (two's complement), 0=DIVU; sampled with start
dividend  input  WIDTH  rs value; sampled with start
divisor  input  WIDTH  rt value; sampled with start
busy  output  1  registered; 1 from the edge accepting start until the result is written
done  output  1  registered; one-cycle pulse in the cycle results first become valid
lo  output  WIDTH  quotient; held stable until the next accepted start
hi  output  WIDTH  remainder; held stable until the next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, lo=0, hi=0; internal counter and working registers cleared. Reset mid-operation abandons the divide with no result update.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge:
  - Latch the magnitudes of the operands (magnitude = raw value when is_signed=0).
  - Latch the sign flags: sq = sign(dividend) XOR sign(divisor); sr = sign(dividend). Both are 0 when unsigned.
  - Latch a div-by-zero flag (divisor==0) and a copy of the raw dividend.
  - Clear partial remainder; count=WIDTH-1; busy<=1; next state CALC.
  - lo/hi are not disturbed.
- CALC, one restoring step per cycle:
  - Form {rem,q} shifted left 1 with the next dividend MSB.
  - If shifted rem >= |divisor|: subtract and set q LSB=1.
  - Compare uses WIDTH+1 bits; no wrap.
  - count==0: next state FIX; else count--.
- FIX, single cycle:
  - lo <= sq ? -q : q; hi <= sr ? -rem : rem.
  - Div-by-zero overrides: lo=all-ones, hi=raw dividend.
  - busy<=0; done<=1 for this one cycle; next state IDLE.
- Latency: busy is high for exactly WIDTH+1 cycles (33 at default). It rises on edge E0 (start accepted) and falls on edge E0+WIDTH+1; done is high during the cycle after that edge.
- Signed overflow: 0x80000000 / -1 yields lo=0x80000000, hi=0. This falls out of magnitude arithmetic and must not be special-cased.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned WIDTH bits.
- start while busy (CALC/FIX): ignored, no effect on the operation in flight.
- start in the IDLE cycle right after done: accepted normally (back-to-back).
- Operand inputs may change freely after the accepting edge.

Optional Feature:
DIV_EARLY_EXIT_EN
- Defined: at the accepting edge, if divisor==0 or |dividend| < |divisor|, go directly to FIX.
  - Remainder is preloaded with |dividend| and the quotient with 0.
  - busy is high exactly 1 cycle; results follow the same sign/div-by-zero rules.
- Not defined: every operation takes WIDTH+1 busy cycles.
- The controller tolerates either, since it waits on busy.

Test Plan:
- DIVU 100/7 (is_signed=0) -> busy high 33 cycles, then lo=14, hi=2, done one pulse.
- DIV -7/2 (0xFFFFFFF9/0x00000002) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
- Div-by-zero: DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234.
  - Without the macro: busy 33 cycles.
  - With DIV_EARLY_EXIT_EN: busy 1 cycle, same result. DIVU 3/10 then also gives busy 1 cycle, lo=0, hi=3.
- start pulsed again mid-CALC with different operands -> original result delivered at cycle 33, no restart. A start in the IDLE cycle after done is accepted.
- rst asserted at cycle 10 of a divide -> busy/done/lo/hi=0 immediately (async); after release, a fresh 100/7 completes correctly.
